// File: rtl/kalman_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the Kalman predict step.
package kalman_pkg;

    localparam int N     = 6;          // state dimension
    localparam int W     = 32;         // element width, signed Q20.12
    localparam int FRAC  = 12;         // fractional bits
    localparam int ACC_W = 2 * W + 4;  // accumulator width, wide enough for N products
    localparam int CW    = 3;          // loop counter width (covers 0..N-1)
    localparam int IW    = 6;          // flat matrix index width (covers 0..N*N-1)

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRED_X   = 3'd1,
        MUL_FP   = 3'd2,
        MUL_FPFT = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    // Row-major position of element (r,c) inside an NxN buffer.
    function automatic logic [IW-1:0] idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return IW'(int'(r) * N + int'(c));
    endfunction

    // True when v does not fit in a signed W-bit element.
    function automatic logic sat_ovf(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // Narrow v to W bits, clipping to the representable range.
    function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return {1'b0, {(W-1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, {(W-1){1'b0}}};
        return v[W-1:0];
    endfunction

endpackage

// File: rtl/kalman_predict_mac.sv
// Shared multiply-accumulate: signed W x W product into a wide accumulator, with a
// combinational shift/offset/saturate view of the running sum including this cycle's product.
module fixed_mac
    import kalman_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,      // accumulate this cycle's product
    input  logic                clr,     // first term of a new element: ignore the old sum
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic signed [W-1:0] addend,  // added after the fractional shift
    output logic signed [W-1:0] result,
    output logic                ovf
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] shifted;

    // Next accumulator value and its rescaled, saturated element value.
    always_comb begin
        prod     = a * b;
        acc_base = clr ? {ACC_W{1'b0}} : acc_q;
        acc_d    = acc_base + ACC_W'(prod);
        shifted  = (acc_d >>> FRAC) + ACC_W'(addend);
        result   = sat_w(shifted);
        ovf      = sat_ovf(shifted);
    end

    // Accumulator register, advanced only while the sequencer issues a MAC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     acc_q <= '0;
        else if (en) acc_q <= acc_d;
    end

endmodule

// File: rtl/kalman_predict.sv
// Kalman predict step: xhat = F*x, Phat = F*P*F^T + Q, one MAC per clock.
// Handshake: start is a level request sampled only in IDLE; done rises once the whole
// result is stable and stays high while start is held; dropping start returns to IDLE
// (done low) on the next edge. Outputs are meaningful only while done is high.
module kalman_predict
    import kalman_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*W-1:0]     x_flat,
    input  logic [N*N*W-1:0]   P_flat,
    input  logic [N*N*W-1:0]   F_flat,
    input  logic [N*N*W-1:0]   Q_flat,
    output logic [N*W-1:0]     xhat_flat,
    output logic [N*N*W-1:0]   Phat_flat,
    output logic               sat_flag,
    output logic               done
);

    state_t state_q, state_d;
    logic [CW-1:0] i_q, j_q, k_q, i_d, j_d, k_d;
    logic k_last, j_last, i_last;
    logic mac_en, wr_en, done_q, sat_q;

    logic signed [W-1:0] x_r    [N];
    logic signed [W-1:0] xhat_r [N];
    logic signed [W-1:0] P_r    [N*N];
    logic signed [W-1:0] F_r    [N*N];
    logic signed [W-1:0] Q_r    [N*N];
    logic signed [W-1:0] fp_r   [N*N];
    logic signed [W-1:0] phat_r [N*N];

    logic signed [W-1:0] mac_a, mac_b, mac_add, mac_res;
    logic mac_ovf;

    assign k_last = (k_q == CW'(N - 1));
    assign j_last = (j_q == CW'(N - 1));
    assign i_last = (i_q == CW'(N - 1));

    // State and loop counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Sequencer: k innermost, then j, then i; an element completes when k wraps.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        mac_en  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRED_X;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            PRED_X: begin
                mac_en = 1'b1;
                wr_en  = k_last;
                if (!k_last) begin
                    k_d = k_q + CW'(1);
                end else begin
                    k_d = '0;
                    if (!i_last) begin
                        i_d = i_q + CW'(1);
                    end else begin
                        i_d     = '0;
                        state_d = MUL_FP;
                    end
                end
            end
            MUL_FP, MUL_FPFT: begin
                mac_en = 1'b1;
                wr_en  = k_last;
                if (!k_last) begin
                    k_d = k_q + CW'(1);
                end else begin
                    k_d = '0;
                    if (!j_last) begin
                        j_d = j_q + CW'(1);
                    end else begin
                        j_d = '0;
                        if (!i_last) begin
                            i_d = i_q + CW'(1);
                        end else begin
                            i_d     = '0;
                            state_d = (state_q == MUL_FP) ? MUL_FPFT : DONE;
                        end
                    end
                end
            end
            DONE: begin
                // Leave only once done has been visible, so a short start pulse still gets a done.
                if (!start && done_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // done rises one edge after entering DONE and drops on the edge that returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= (state_q == DONE) && (state_d != IDLE);
    end

    // Operand selection; F^T comes from swapping F's indices in the last product.
    always_comb begin
        mac_a   = '0;
        mac_b   = '0;
        mac_add = '0;
        unique case (state_q)
            PRED_X: begin
                mac_a = F_r[idx(i_q, k_q)];
                mac_b = x_r[k_q];
            end
            MUL_FP: begin
                mac_a = F_r[idx(i_q, k_q)];
                mac_b = P_r[idx(k_q, j_q)];
            end
            MUL_FPFT: begin
                mac_a   = fp_r[idx(i_q, k_q)];
                mac_b   = F_r[idx(j_q, k_q)];
                mac_add = Q_r[idx(i_q, j_q)];
            end
            default: ;
        endcase
    end

    fixed_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .en     (mac_en),
        .clr    (k_q == '0),
        .a      (mac_a),
        .b      (mac_b),
        .addend (mac_add),
        .result (mac_res),
        .ovf    (mac_ovf)
    );

    // Operand capture on start, element write-back, and sticky saturation flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < N; e++) begin
                x_r[e]    <= '0;
                xhat_r[e] <= '0;
            end
            for (int e = 0; e < N*N; e++) begin
                P_r[e]    <= '0;
                F_r[e]    <= '0;
                Q_r[e]    <= '0;
                fp_r[e]   <= '0;
                phat_r[e] <= '0;
            end
            sat_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                for (int e = 0; e < N; e++)
                    x_r[e] <= x_flat[W*(N-1-e) +: W];
                for (int e = 0; e < N*N; e++) begin
                    P_r[e] <= P_flat[W*(N*N-1-e) +: W];
                    F_r[e] <= F_flat[W*(N*N-1-e) +: W];
                    Q_r[e] <= Q_flat[W*(N*N-1-e) +: W];
                end
                sat_q <= 1'b0;
            end
            if (wr_en) begin
                unique case (state_q)
                    PRED_X:   xhat_r[i_q]            <= mac_res;
                    MUL_FP:   fp_r[idx(i_q, j_q)]    <= mac_res;
                    MUL_FPFT: phat_r[idx(i_q, j_q)]  <= mac_res;
                    default: ;
                endcase
                if (mac_ovf) sat_q <= 1'b1;
            end
        end
    end

    // Pack the result registers into the row-major, MSB-first output buses.
    always_comb begin
        xhat_flat = '0;
        Phat_flat = '0;
        for (int e = 0; e < N; e++)
            xhat_flat[W*(N-1-e) +: W] = xhat_r[e];
        for (int e = 0; e < N*N; e++)
            Phat_flat[W*(N*N-1-e) +: W] = phat_r[e];
    end

    assign done     = done_q;
    assign sat_flag = sat_q;

endmodule
